// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered CH:1 mux with manual select, dwell-timed auto scan and valid/ready output; `MUX_SCAN_MASK_EN adds ch_mask skipping
module mux_scan_sel #(
  parameter int CH = 8,
  parameter int W = 1,
  parameter int SELW = 3,
  parameter int DWELL = 4
) (
  input logic clk,
  input logic rst_n,
  input logic strobe_n,
  input logic mode,
  input logic [SELW-1:0] sel,
  input logic [CH*W-1:0] din,
`ifdef MUX_SCAN_MASK_EN
  input logic [CH-1:0] ch_mask,
`endif
  output logic [W-1:0] z,
  output logic [W-1:0] z_n,
  output logic [SELW-1:0] ch_out,
  output logic valid,
  input logic ready,
  output logic wrap,
  output logic sel_err
);
  logic [CH-1:0] msk;
  logic [SELW-1:0] scan, cur, last;
  logic [7:0] dwell;
  logic [W-1:0] d_sel, d_cur, d_man;
  logic mode_q, from_scan, any, free, mode_chg, sel_bad;
`ifdef MUX_SCAN_MASK_EN
  assign msk = ch_mask;
`else
  assign msk = '0;
`endif
  assign any = |(~msk);
  assign free = !valid || ready;
  assign mode_chg = mode != mode_q;
  assign sel_bad = int'(sel) >= CH;
  assign d_man = sel_bad ? '0 : d_sel;
  assign wrap = valid && ready && from_scan && any && ch_out == last;
  always_comb begin
    cur = scan;
    last = '0;
    d_sel = '0;
    d_cur = '0;
    for (int i = CH-1; i >= 0; i--)
      if (!msk[(int'(scan)+i)%CH]) cur = SELW'((int'(scan)+i)%CH);
    for (int k = 0; k < CH; k++) begin
      if (!msk[k]) last = SELW'(k);
      if (sel == SELW'(k)) d_sel = din[k*W +: W];
      if (cur == SELW'(k)) d_cur = din[k*W +: W];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      z <= '0;
      z_n <= '1;
      ch_out <= '0;
      valid <= 1'b0;
      sel_err <= 1'b0;
      scan <= '0;
      dwell <= '0;
      mode_q <= 1'b0;
      from_scan <= 1'b0;
    end else begin
      mode_q <= mode;
      sel_err <= 1'b0;
      if (strobe_n) begin
        z <= '0;
        z_n <= '1;
        valid <= 1'b0;
        scan <= '0;
        dwell <= '0;
      end else if (!mode) begin
        scan <= '0;
        dwell <= '0;
        if (free) begin
          z <= d_man;
          z_n <= ~d_man;
          ch_out <= sel;
          valid <= 1'b1;
          from_scan <= 1'b0;
          sel_err <= sel_bad;
        end
      end else if (mode_chg) begin
        scan <= '0;
        dwell <= '0;
        if (ready) valid <= 1'b0;
      end else if (free && any) begin
        if (dwell == 8'(DWELL-1)) begin
          z <= d_cur;
          z_n <= ~d_cur;
          ch_out <= cur;
          valid <= 1'b1;
          from_scan <= 1'b1;
          dwell <= '0;
          scan <= (cur == SELW'(CH-1)) ? '0 : cur + 1'b1;
        end else begin
          dwell <= dwell + 8'd1;
          valid <= 1'b0;
        end
      end else if (ready) valid <= 1'b0;
    end
endmodule
